// File: rtl/upsample_pkg.sv
// ---------------------------------------------------------------------------
// upsample_pkg
// Shared types and helpers for the nearest-neighbour 2-D upsampler.
//   state_e    : top-level sequencing state (PASS = consume input rows,
//                REPLAY = re-emit the buffered row from the line buffer)
//   cnt_width  : bit width needed to hold a counter that runs 0..n-1,
//                never less than one bit so degenerate factors of 1 still
//                produce legal vectors.
// Optional feature macro used by the top: UPSAMPLE_NEAREST2D_FRAME_LAST_EN.
// ---------------------------------------------------------------------------
package upsample_pkg;

    typedef enum logic [0:0] {
        PASS   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/upsample_line_buffer.sv
// ---------------------------------------------------------------------------
// upsample_line_buffer
// Simple dual-port row store for the upsampler: one write port, one read
// port, no reset (contents are don't-care until a row has been written).
// The read is asynchronous so the replay path can present a new element on
// every cycle without a prefetch stage.
// Ports:
//   clk      : clock
//   we_i     : write enable
//   waddr_i  : write address (column index)
//   wdata_i  : write data
//   raddr_i  : read address (column index)
//   rdata_o  : read data, combinational from raddr_i
// ---------------------------------------------------------------------------
module upsample_line_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/upsample_nearest2d.sv
// ---------------------------------------------------------------------------
// upsample_nearest2d
// Streaming 2-D nearest-neighbour upsampler. A row-major raster of
// IN_HEIGHT x IN_WIDTH elements is expanded to
// (IN_HEIGHT*SCALE_H) x (IN_WIDTH*SCALE_W): each element is repeated SCALE_W
// times, and each completed row is replayed SCALE_H-1 more times from a line
// buffer while the input is held off.
// Ports:
//   clk               : clock
//   rst               : asynchronous, active-low reset
//   data_in_0         : input element
//   data_in_0_valid   : input beat valid
//   data_in_0_ready   : input beat accepted when valid && ready
//   data_out_0        : output element (registered)
//   data_out_0_valid  : output beat valid (registered)
//   data_out_0_ready  : downstream accepts
//   data_out_0_last   : (only with UPSAMPLE_NEAREST2D_FRAME_LAST_EN) high on
//                       the final output beat of each frame (registered)
// ---------------------------------------------------------------------------
module upsample_nearest2d
    import upsample_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 3,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 3,
    parameter int IN_WIDTH               = 4,
    parameter int IN_HEIGHT              = 4,
    parameter int SCALE_W                = 2,
    parameter int SCALE_H                = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
    input  logic                              data_in_0_valid,
    output logic                              data_in_0_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
    output logic                              data_out_0_valid,
    input  logic                              data_out_0_ready
`ifdef UPSAMPLE_NEAREST2D_FRAME_LAST_EN
    ,
    output logic                              data_out_0_last
`endif
);

    localparam int DW     = DATA_IN_0_PRECISION_0;
    localparam int COL_W  = cnt_width(IN_WIDTH);
    localparam int ROW_W  = cnt_width(IN_HEIGHT);
    localparam int REPW_W = cnt_width(SCALE_W);
    localparam int REPH_W = cnt_width(SCALE_H);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IN_HEIGHT - 1);
    localparam logic [REPW_W-1:0] REPW_LAST = REPW_W'(SCALE_W - 1);
    localparam logic [REPH_W-1:0] REPH_LAST = REPH_W'(SCALE_H - 1);

    // Elaboration-time parameter sanity checks.
    if (DATA_IN_0_PRECISION_0 != DATA_OUT_0_PRECISION_0) begin : g_bad_width
        $error("upsample_nearest2d: input and output widths must match");
    end
    if (DATA_IN_0_PRECISION_1 != DATA_OUT_0_PRECISION_1) begin : g_bad_frac
        $error("upsample_nearest2d: input and output fractional bits must match");
    end
    if (IN_WIDTH < 1 || IN_HEIGHT < 1 || SCALE_W < 1 || SCALE_H < 1) begin : g_bad_dims
        $error("upsample_nearest2d: dimensions and scale factors must be >= 1");
    end

    state_e            state_q,  state_d;
    logic [COL_W-1:0]  col_q,    col_d;
    logic [ROW_W-1:0]  row_q,    row_d;
    logic [REPW_W-1:0] rep_w_q,  rep_w_d;
    logic [REPH_W-1:0] rep_h_q,  rep_h_d;
    logic [DW-1:0]     out_q,    out_d;
    logic              valid_q,  valid_d;
    logic [DW-1:0]     cur_q,    cur_d;

    logic              slot_free;
    logic              in_ready;
    logic              accept;
    logic              repeat_fire;
    logic              fire;
    logic [DW-1:0]     lb_rdata;

    // The output register may take a new beat when empty or being drained.
    assign slot_free   = !valid_q || data_out_0_ready;
    assign in_ready    = slot_free && (state_q == PASS) && (rep_w_q == '0);
    assign accept      = data_in_0_valid && in_ready;
    // Beats produced without consuming input: horizontal repeats of the
    // current element in PASS, or any buffered element in REPLAY.
    assign repeat_fire = slot_free && ((state_q == REPLAY) || (rep_w_q != '0));
    assign fire        = accept || repeat_fire;

    upsample_line_buffer #(
        .DEPTH (IN_WIDTH),
        .WIDTH (DW),
        .AW    (COL_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (col_q),
        .wdata_i (data_in_0),
        .raddr_i (col_q),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rep_w_d = rep_w_q;
        rep_h_d = rep_h_q;
        out_d   = out_q;
        valid_d = valid_q;
        cur_d   = cur_q;

        if (slot_free) begin
            valid_d = fire;
        end

        if (accept) begin
            out_d = data_in_0;
            cur_d = data_in_0;
        end else if (repeat_fire) begin
            out_d = (state_q == PASS) ? cur_q : lb_rdata;
        end

        // Position counters step once per emitted beat: rep_w innermost,
        // then col, then either the row replay count or the row itself.
        if (fire) begin
            if (rep_w_q == REPW_LAST) begin
                rep_w_d = '0;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if ((state_q == PASS) && (SCALE_H > 1)) begin
                        state_d = REPLAY;
                        rep_h_d = REPH_W'(1);
                    end else if ((state_q == REPLAY) && (rep_h_q != REPH_LAST)) begin
                        rep_h_d = rep_h_q + 1'b1;
                    end else begin
                        rep_h_d = '0;
                        state_d = PASS;
                        row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end else begin
                rep_w_d = rep_w_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PASS;
            col_q   <= '0;
            row_q   <= '0;
            rep_w_q <= '0;
            rep_h_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            rep_w_q <= rep_w_d;
            rep_h_q <= rep_h_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            cur_q   <= cur_d;
        end
    end

    assign data_in_0_ready  = in_ready;
    assign data_out_0       = out_q;
    assign data_out_0_valid = valid_q;

`ifdef UPSAMPLE_NEAREST2D_FRAME_LAST_EN
    logic last_q, last_d;
    logic frame_end_pos;

    // The beat about to be emitted is the last of the frame when every
    // counter sits at its final value.
    assign frame_end_pos = (row_q == ROW_LAST) && (rep_h_q == REPH_LAST) &&
                           (col_q == COL_LAST) && (rep_w_q == REPW_LAST);

    always_comb begin
        last_d = last_q;
        if (slot_free) begin
            last_d = fire && frame_end_pos;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

    assign data_out_0_last = last_q;
`endif

endmodule
